// File: rtl/servo_pkg.sv
// servo_pkg: shared types and default constants for the servo slew limiter.
// Provides the pulse-width type, the slew state enum, default clamp/centre
// values and a clamp helper.
package servo_pkg;

    localparam int unsigned PW_W         = 11;
    localparam int unsigned PW_MIN_DEF   = 1000;
    localparam int unsigned PW_MAX_DEF   = 2000;
    localparam int unsigned PW_INIT_DEF  = 1500;
    localparam int unsigned MAX_STEP_DEF = 16;

    typedef logic [PW_W-1:0] pw_t;

    typedef enum logic [1:0] {
        SETTLED = 2'd0,
        SLEWING = 2'd1,
        HOLD    = 2'd2
    } slew_state_t;

    // Saturate a requested pulse width into [lo, hi].
    function automatic pw_t clamp_pw(input pw_t x, input pw_t lo, input pw_t hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/servo_slew_limiter_if.sv
// servo_slew_limiter_if: target/command bundle between the coordinate
// transform (master) and the slew limiter (slave).
//   target_valid/target_pan/target_tilt : new target strobe and values
//   hold                                : freeze commanded outputs
//   pan_pw/tilt_pw                      : commanded pulse widths, us
//   settled                             : both axes at target, not held
//   tick                                : one-cycle slew update pulse
interface servo_slew_limiter_if;

    logic             target_valid;
    servo_pkg::pw_t   target_pan;
    servo_pkg::pw_t   target_tilt;
    logic             hold;
    servo_pkg::pw_t   pan_pw;
    servo_pkg::pw_t   tilt_pw;
    logic             settled;
    logic             tick;

    modport master (
        output target_valid, target_pan, target_tilt, hold,
        input  pan_pw, tilt_pw, settled, tick
    );

    modport slave (
        input  target_valid, target_pan, target_tilt, hold,
        output pan_pw, tilt_pw, settled, tick
    );

endinterface

// File: rtl/slew_channel.sv
// slew_channel: one servo axis. Clamps and latches a target, then moves the
// commanded pulse width toward it by a bounded step whenever step_en is high.
// Optional macro SERVO_SLEW_ACCEL_EN: step size ramps 1..MAX_STEP while the
// axis keeps moving the same way; reset to 1 on reversal, arrival or hold.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   tgt_valid     : latch tgt_in (clamped) this cycle
//   tgt_in        : requested pulse width, us
//   step_en       : perform one slew step this cycle
//   hold          : outputs frozen
//   pw            : commanded pulse width (registered)
//   at_target     : pw equals latched target (registered)
module slew_channel
    import servo_pkg::*;
#(
    parameter int unsigned MAX_STEP = MAX_STEP_DEF,
    parameter int unsigned PW_MIN   = PW_MIN_DEF,
    parameter int unsigned PW_MAX   = PW_MAX_DEF,
    parameter int unsigned PW_INIT  = PW_INIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tgt_valid,
    input  pw_t  tgt_in,
    input  logic step_en,
    input  logic hold,
    output pw_t  pw,
    output logic at_target
);

    pw_t               tgt_q, tgt_d;
    pw_t               pw_q, pw_d;
    logic              at_target_q, at_target_d;
    logic signed [11:0] diff_c;
    pw_t               mag_c;
    logic              up_c;
    pw_t               step_c;
    pw_t               move_c;
    logic              move_c_en;

`ifdef SERVO_SLEW_ACCEL_EN
    pw_t  step_q, step_d;
    logic dir_up_q, dir_up_d;
`endif

    // Target latch, step sizing and next pulse width.
    always_comb begin
        tgt_d = tgt_q;
        if (tgt_valid) begin
            tgt_d = clamp_pw(tgt_in, pw_t'(PW_MIN), pw_t'(PW_MAX));
        end

        diff_c = signed'({1'b0, tgt_q}) - signed'({1'b0, pw_q});
        up_c   = ~diff_c[11];
        mag_c  = diff_c[11] ? pw_t'(-diff_c) : pw_t'(diff_c);

`ifdef SERVO_SLEW_ACCEL_EN
        // A reversal restarts the ramp on this very move.
        step_c = (dir_up_q != up_c) ? pw_t'(1) : step_q;
`else
        step_c = pw_t'(MAX_STEP);
`endif
        move_c    = (mag_c <= step_c) ? mag_c : step_c;
        move_c_en = step_en && !hold && (mag_c != '0);

        pw_d = pw_q;
        if (move_c_en) begin
            pw_d = up_c ? (pw_q + move_c) : (pw_q - move_c);
        end

        at_target_d = (pw_d == tgt_d);

`ifdef SERVO_SLEW_ACCEL_EN
        step_d   = step_q;
        dir_up_d = dir_up_q;
        if (hold) begin
            step_d = pw_t'(1);
        end else if (move_c_en) begin
            dir_up_d = up_c;
            if (mag_c <= step_c) begin
                step_d = pw_t'(1);
            end else if (step_c >= pw_t'(MAX_STEP)) begin
                step_d = pw_t'(MAX_STEP);
            end else begin
                step_d = step_c + pw_t'(1);
            end
        end
`endif
    end

    // Channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q       <= pw_t'(PW_INIT);
            pw_q        <= pw_t'(PW_INIT);
            at_target_q <= 1'b1;
`ifdef SERVO_SLEW_ACCEL_EN
            step_q      <= pw_t'(1);
            dir_up_q    <= 1'b1;
`endif
        end else begin
            tgt_q       <= tgt_d;
            pw_q        <= pw_d;
            at_target_q <= at_target_d;
`ifdef SERVO_SLEW_ACCEL_EN
            step_q      <= step_d;
            dir_up_q    <= dir_up_d;
`endif
        end
    end

    assign pw        = pw_q;
    assign at_target = at_target_q;

endmodule

// File: rtl/servo_slew_limiter.sv
// servo_slew_limiter: rate-limits pan/tilt servo pulse-width commands.
// Owns the update tick counter, the SETTLED/SLEWING/HOLD state machine and
// the settled flag; each axis is a slew_channel instance.
// Optional macro SERVO_SLEW_ACCEL_EN enables per-axis step acceleration.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : servo_slew_limiter_if.slave (targets, hold, pw outputs,
//              settled, tick)
module servo_slew_limiter
    import servo_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY_MHZ = 50,
    parameter int unsigned UPDATE_PERIOD_US    = 20000,
    parameter int unsigned MAX_STEP            = MAX_STEP_DEF,
    parameter int unsigned PW_MIN              = PW_MIN_DEF,
    parameter int unsigned PW_MAX              = PW_MAX_DEF,
    parameter int unsigned PW_INIT             = PW_INIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    servo_slew_limiter_if.slave  bus
);

    localparam int unsigned TICK_CYCLES = CLOCK_FREQUENCY_MHZ * UPDATE_PERIOD_US;
    localparam int unsigned CNT_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_c;
    logic             tick_q;
    logic             settled_q, settled_d;
    slew_state_t      state_q, state_d;
    logic             step_en_c;
    logic             pan_at_c, tilt_at_c;
    logic             all_at_c;

    // Free-running update counter; the step lands on the wrap edge so pw and
    // tick change together.
    always_comb begin
        wrap_c = (cnt_q == CNT_W'(TICK_CYCLES - 1));
        cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end

    assign all_at_c = pan_at_c && tilt_at_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SETTLED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SETTLED: begin
                if (bus.hold)       state_d = HOLD;
                else if (!all_at_c) state_d = SLEWING;
            end
            SLEWING: begin
                if (bus.hold)       state_d = HOLD;
                else if (all_at_c)  state_d = SETTLED;
            end
            HOLD: begin
                if (!bus.hold)      state_d = all_at_c ? SETTLED : SLEWING;
            end
            default:                state_d = SETTLED;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        step_en_c = 1'b0;
        settled_d = (state_d == SETTLED);
        if ((state_q == SLEWING) && wrap_c && !bus.hold) begin
            step_en_c = 1'b1;
        end
    end

    // Counter, tick and settled registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= wrap_c;
            settled_q <= settled_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.settled = settled_q;

    slew_channel #(
        .MAX_STEP (MAX_STEP),
        .PW_MIN   (PW_MIN),
        .PW_MAX   (PW_MAX),
        .PW_INIT  (PW_INIT)
    ) u_pan (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (bus.target_valid),
        .tgt_in    (bus.target_pan),
        .step_en   (step_en_c),
        .hold      (bus.hold),
        .pw        (bus.pan_pw),
        .at_target (pan_at_c)
    );

    slew_channel #(
        .MAX_STEP (MAX_STEP),
        .PW_MIN   (PW_MIN),
        .PW_MAX   (PW_MAX),
        .PW_INIT  (PW_INIT)
    ) u_tilt (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (bus.target_valid),
        .tgt_in    (bus.target_tilt),
        .step_en   (step_en_c),
        .hold      (bus.hold),
        .pw        (bus.tilt_pw),
        .at_target (tilt_at_c)
    );

endmodule

// File: tb/tb_servo_slew_limiter.sv
// tb_servo_slew_limiter: directed bench for servo_slew_limiter with a short
// 20-cycle update period. Inputs change and outputs are sampled on negedge.
module tb_servo_slew_limiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    servo_slew_limiter_if bus();

    servo_slew_limiter #(
        .CLOCK_FREQUENCY_MHZ (1),
        .UPDATE_PERIOD_US    (20),
        .MAX_STEP            (16),
        .PW_MIN              (1000),
        .PW_MAX              (2000),
        .PW_INIT             (1500)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to the negedge of the next tick cycle, bounded.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.tick) seen = 1'b1;
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    task automatic send(input int p, input int t);
        bus.target_valid = 1'b1;
        bus.target_pan   = 11'(p);
        bus.target_tilt  = 11'(t);
        @(negedge clk);
        bus.target_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.target_valid = 1'b0;
        bus.target_pan   = '0;
        bus.target_tilt  = '0;
        bus.hold         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pan", int'(bus.pan_pw), 1500);
        check("rst_tilt", int'(bus.tilt_pw), 1500);
        check("rst_settled", int'(bus.settled), 1);
        check("rst_tick", int'(bus.tick), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_settled", int'(bus.settled), 1);

        // Idle for three ticks: nothing moves.
        repeat (3) wait_tick();
        check("idle_pan", int'(bus.pan_pw), 1500);
        check("idle_tilt", int'(bus.tilt_pw), 1500);
        check("idle_settled", int'(bus.settled), 1);

`ifndef SERVO_SLEW_ACCEL_EN
        // Large jump 1500 -> 2000: 31 steps of 16 then a final 4.
        wait_tick();
        send(2000, 1500);
        for (int k = 1; k <= 32; k++) begin
            wait_tick();
            check("jump_pan", int'(bus.pan_pw), (k < 32) ? 1500 + 16 * k : 2000);
            if (k == 1) begin
                check("jump_tilt", int'(bus.tilt_pw), 1500);
                check("jump_slewing", int'(bus.settled), 0);
            end
        end
        check("jump_settled_pre", int'(bus.settled), 0);
        @(negedge clk);
        check("tick_width", int'(bus.tick), 0);
        check("jump_settled", int'(bus.settled), 1);

        // Clamp 300 -> 1000 on pan, small move on tilt.
        wait_tick();
        send(300, 1510);
        for (int k = 1; k <= 63; k++) begin
            wait_tick();
            check("clamp_pan", int'(bus.pan_pw), (2000 - 16 * k > 1000) ? 2000 - 16 * k : 1000);
            if (k == 1) check("small_tilt", int'(bus.tilt_pw), 1510);
        end
        repeat (2) wait_tick();
        check("clamp_pan_floor", int'(bus.pan_pw), 1000);
        check("clamp_tilt_hold", int'(bus.tilt_pw), 1510);
        check("clamp_settled", int'(bus.settled), 1);

        // Reset returns outputs to centre immediately.
        rst = 1'b1;
        @(negedge clk);
        check("rst2_pan", int'(bus.pan_pw), 1500);
        check("rst2_tilt", int'(bus.tilt_pw), 1500);
        rst = 1'b0;

        // Retarget mid-slew; 2047 clamps to 2000.
        wait_tick();
        send(2047, 1500);
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            check("retgt_pan", int'(bus.pan_pw), 1500 + 16 * k);
        end
        send(1540, 1500);
        wait_tick();
        check("retgt_final", int'(bus.pan_pw), 1540);
        @(negedge clk);
        check("retgt_settled", int'(bus.settled), 1);

        // Hold freezes a slew; last of back-to-back targets wins.
        wait_tick();
        send(1000, 1500);
        wait_tick();
        check("hold_pre1", int'(bus.pan_pw), 1524);
        wait_tick();
        check("hold_pre2", int'(bus.pan_pw), 1508);
        bus.hold = 1'b1;
        @(negedge clk);
        check("hold_settled", int'(bus.settled), 0);
        send(1700, 1500);
        send(1000, 1500);
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            check("hold_frozen", int'(bus.pan_pw), 1508);
        end
        check("hold_settled_end", int'(bus.settled), 0);
        bus.hold = 1'b0;
        wait_tick();
        check("resume1", int'(bus.pan_pw), 1492);
        wait_tick();
        check("resume2", int'(bus.pan_pw), 1476);
        check("resume_settled", int'(bus.settled), 0);

        // Reset in the middle of the slew.
        rst = 1'b1;
        @(negedge clk);
        check("rst3_pan", int'(bus.pan_pw), 1500);
        rst = 1'b0;
        @(negedge clk);
        check("rst3_settled", int'(bus.settled), 1);

        // Tilt target 0 clamps to 1000: 500 = 31*16 + 4.
        wait_tick();
        send(1500, 0);
        wait_tick();
        check("tilt_low1", int'(bus.tilt_pw), 1484);
        repeat (31) wait_tick();
        check("tilt_low_final", int'(bus.tilt_pw), 1000);
        check("tilt_low_pan", int'(bus.pan_pw), 1500);
        @(negedge clk);
        check("tilt_low_settled", int'(bus.settled), 1);
`else
        // Accelerating ramp 1500 -> 2000: steps 1,2,..,16 then 16.
        wait_tick();
        send(2000, 1500);
        for (int k = 1; k <= 20; k++) begin
            wait_tick();
            check("accel_pan", int'(bus.pan_pw),
                  (k <= 16) ? 1500 + (k * (k + 1)) / 2 : 1636 + 16 * (k - 16));
        end
        // Reversal restarts at step 1.
        send(1000, 1500);
        wait_tick();
        check("accel_rev1", int'(bus.pan_pw), 1699);
        wait_tick();
        check("accel_rev2", int'(bus.pan_pw), 1697);
        check("accel_tilt", int'(bus.tilt_pw), 1500);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/servo_slew_limiter.md
Name: servo_slew_limiter

Overview:
- Sits between the coordinate transform (pan/tilt pulse-width targets) and the two servo PWM instances.
- Latches new pan/tilt targets, clamps them to the safe mechanical range, and ramps each commanded pulse width toward its target by a bounded step once per servo update tick.
- Prevents mechanical jerk and brown-out when the tracked centroid jumps across the frame.
- Reports when both axes have reached their targets.

Parameters:
- CLOCK_FREQUENCY_MHZ, 50, system clock frequency used to derive the update tick.
- UPDATE_PERIOD_US, 20000, interval between slew steps (one servo frame).
- MAX_STEP, 16, maximum pulse-width change per tick per axis, in us.
- PW_MIN, 1000, lower clamp, in us.
- PW_MAX, 2000, upper clamp, in us.
- PW_INIT, 1500, reset/centre pulse width, in us.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  synchronous active-high reset.
- target_valid  input  1  single-cycle strobe; target_pan/target_tilt are sampled when high.
- target_pan  input  11  requested pan pulse width, us.
- target_tilt  input  11  requested tilt pulse width, us.
- hold  input  1  freeze both outputs at their current values; targets are still latched.
- pan_pw  output  11  commanded pan pulse width to the servo.
- tilt_pw  output  11  commanded tilt pulse width to the servo.
- settled  output  1  high when both outputs equal their latched targets and hold is low.
- tick  output  1  one-cycle pulse at each slew update; intended for debug/LED.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: pan_pw = tilt_pw = PW_INIT; latched targets = PW_INIT; settled = 1; tick = 0; tick counter = 0; state = SETTLED.
- Tick generator: counter 0..CLOCK_FREQUENCY_MHZ*UPDATE_PERIOD_US-1 (1,000,000 cycles at defaults). tick is high for the one cycle in which the counter wraps to 0. The counter free-runs and is unaffected by hold.
- Target latch: on target_valid, each target is clamped to [PW_MIN, PW_MAX] and registered. The latched value is visible to the slew logic on the next cycle.
- Back-to-back target_valid: the last one wins; no queueing.
- target_valid coincident with tick: the step on that tick uses the previously latched target.
- Per-axis step on tick (hold low):
  - diff = target - pw, computed as a signed 12-bit value.
  - If |diff| <= MAX_STEP, pw <= target.
  - Otherwise pw <= pw ± MAX_STEP in the sign of diff.
  - Never overshoot; never leave [PW_MIN, PW_MAX].
- Axes are independent and step on the same tick.
- State machine (single, covering both axes):
  - SETTLED: outputs equal targets. Any latched target differing from its output -> SLEWING on the next cycle; settled deasserts in that cycle.
  - SLEWING: steps on each tick. When both outputs equal their targets after a step -> SETTLED; settled asserts in the cycle after the final step.
  - HOLD: entered from either state when hold = 1; outputs frozen, settled = 0. On hold = 0, go to SLEWING if any mismatch, else SETTLED.
- settled is registered: = (state == SETTLED).
- Outputs are registered and change only on tick cycles or on reset.
- Reset mid-slew: outputs return to PW_INIT in the next cycle, with no ramp.
- Out-of-range inputs: 0 -> clamped to PW_MIN; 2047 -> clamped to PW_MAX.

Optional Feature:
- Macro SERVO_SLEW_ACCEL_EN.
- Defined: each axis keeps a step register (reset 1). On each tick where the axis moves in the same direction as on its previous move, step = min(step + 1, MAX_STEP). On a direction reversal, arrival at target, or hold, step resets to 1. The move size is min(|diff|, step).
- Not defined: fixed step of MAX_STEP, as described above; no step registers are synthesized.

Decomposition:
- Package servo_pkg:
  - typedef pw_t (logic [10:0]);
  - typedef enum slew_state_t {SETTLED, SLEWING, HOLD};
  - default constants for PW_MIN, PW_MAX, PW_INIT.
- Sub-module slew_channel, instantiated twice (pan, tilt):
  - clamps and latches one target;
  - computes one bounded step per tick, including the optional acceleration register;
  - outputs pw and at_target.
- Top level owns the tick counter, the state machine, and settled.

Test Plan:
- Reset: after rst, pan_pw = tilt_pw = 1500, settled = 1; hold for 3 ticks with no target -> values unchanged.
- Large jump: target_pan = 2000, target_tilt = 1500 -> pan_pw steps 1516, 1532, … reaching 2000 exactly on tick 32 (500 = 31×16 + 4); tilt_pw stays 1500; settled rises one cycle after tick 32.
- Clamp and small move: target_pan = 300, target_tilt = 1510 -> pan ramps down and stops at 1000 (never below); tilt reaches 1510 on the first tick.
- Retarget mid-slew: start 1500 -> 2000; after 3 ticks (pan_pw = 1548) set target 1540 -> next tick pan_pw = 1540, no overshoot, settled = 1.
- Hold and reset: hold = 1 during a slew -> outputs frozen across 5 ticks and settled = 0; release -> slewing resumes. Assert rst mid-slew -> outputs 1500 the next cycle.
- SERVO_SLEW_ACCEL_EN defined: 1500 -> 2000 gives per-tick steps 1, 2, 3, … up to 16, then 16 thereafter; a reversal resets the step to 1.
